timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Counting stage directly downstream of the timer register block.
- Consumes its control and command outputs: enable, divider settings, halt request, clear and direct counter writes.
- Produces the 64-bit count value and the halt-acknowledge status, which the register block reads back and the interrupt block compares.
- Contains the clock prescaler, the 64-bit up-counter and the debug-halt handshake.

Parameters:
- CNT_W, 64, counter width; fixed as two 32-bit words.
- PRE_W, 8, prescaler width; supports division ratios up to 2^8.

Ports:
- sys_clk  input  1  system clock; all state updates on its rising edge.
- sys_rst  input  1  reset; asynchronous, active-high.
- timer_en  input  1  count enable.
- div_en  input  1  1 = count on prescaler tick; 0 = count every cycle.
- div_val  input  4  division exponent; ratio = 2^div_val, legal range 0..8.
- halt_req  input  1  debug halt request.
- dbg_mode  input  1  debug mode indicator; halt is honoured only when this is 1.
- counter_clear  input  1  one-cycle pulse; zeroes counter and prescaler.
- counter_write_sel  input  2  bit0 = write low word, bit1 = write high word; one-cycle pulses.
- counter_write_data  input  32  write data for the selected word(s).
- cnt_val  output  64  current count, registered.
- halt_ack_status  output  1  halt acknowledge, registered.

Behaviour:
- Reset (sys_rst=1, async): cnt_val=0, prescaler=0, halt_ack_status=0. All held until reset deasserts.
- Halt handshake:
  - halt_ack_status <= halt_req & dbg_mode every cycle, i.e. one cycle of latency in each direction.
  - halted = halt_ack_status (registered value).
  - The count may therefore advance once in the cycle that halt_req rises.
- Prescaler:
  - limit = (1<<div_val) - 1, 9-bit arithmetic; div_val > 8 is saturated to 8.
  - Active (timer_en=1, div_en=1, !halted): if prescaler >= limit, tick=1 and prescaler <= 0; else prescaler <= prescaler + 1.
  - The >= compare guarantees an immediate tick if the limit is reduced below the current prescaler value.
  - timer_en=0 or div_en=0: prescaler <= 0; tick = (timer_en & !div_en).
  - Halted: prescaler holds and tick=0.
- Counter update priority, evaluated per cycle:
  1. counter_clear=1: cnt_val <= 0 and prescaler <= 0. Any write or tick in the same cycle is ignored.
  2. Else if counter_write_sel != 0:
     - bit0 loads cnt_val[31:0] and bit1 loads cnt_val[63:32], both from counter_write_data.
     - Both bits set loads both words with the same data.
     - Unselected word holds; no increment this cycle. A tick coinciding with a write is dropped, but the prescaler still advances or resets normally.
  3. Else if tick: cnt_val <= cnt_val + 1. Full 64-bit carry from low to high word; 0xFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
  4. Else hold.
- Writes and clear are accepted while halted and while timer_en=0.
- Latency:
  - div_en=0: first increment occurs at the first rising edge where timer_en=1 is sampled.
  - div_en=1: first increment occurs at the 2^div_val-th such edge, then every 2^div_val cycles.
- timer_en falling: counting stops at that edge and the prescaler clears. cnt_val holds until counter_clear arrives (the register block issues it one cycle later).
- No combinational path from any input to any output.

Test Plan:
- Reset, then timer_en=1, div_en=0 for 10 cycles -> cnt_val = 10; assert sys_rst mid-count -> cnt_val = 0 immediately (async), halt_ack_status = 0.
- div_en=1, div_val=3, timer_en=1 for 40 cycles -> cnt_val = 5, incrementing on cycles 8, 16, 24, 32, 40; repeat with div_val=0 -> increments every cycle.
- Write low word 0xFFFF_FFFF and high word 0x0000_0001, then 1 tick -> cnt_val = 0x0000_0002_0000_0000; load all-ones, 1 tick -> cnt_val = 0.
- Count running, assert halt_req with dbg_mode=1 -> halt_ack_status = 1 next cycle, cnt_val frozen (at most one extra increment); drop dbg_mode -> ack = 0 next cycle and counting resumes from the frozen value. halt_req with dbg_mode=0 -> no ack, no freeze.
- counter_clear and counter_write_sel=2'b01 in the same cycle, with a tick pending -> cnt_val = 0 and prescaler = 0.
- Write to low word coinciding with a tick -> low word = written data, high word unchanged, no increment; the next tick increments from the written value.

Source files
------------

// File: rtl/timer_counter.sv
// Timer counting stage: clock prescaler, 64-bit up-counter and debug-halt
// handshake, fed by the timer register block.
module timer_counter #(
   parameter int CNT_W = 64,
   parameter int PRE_W = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             timer_en,
   input  logic             div_en,
   input  logic [3:0]       div_val,
   input  logic             halt_req,
   input  logic             dbg_mode,
   input  logic             counter_clear,
   input  logic [1:0]       counter_write_sel,
   input  logic [31:0]      counter_write_data,
   output logic [CNT_W-1:0] cnt_val,
   output logic             halt_ack_status
);

   localparam int LIM_W = PRE_W + 1;
   localparam int HALF  = CNT_W / 2;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             halt_q, halt_d;

   logic [3:0]       div_sat;
   logic [LIM_W-1:0] limit;
   logic [LIM_W-1:0] pre_ext;
   logic             halted;
   logic             pre_active;
   logic             tick;
   logic             wr_any;

   // Division exponent saturated to the prescaler width, and the tick limit
   always_comb begin
      div_sat = div_val;
      if (div_val > 4'(PRE_W)) begin
         div_sat = 4'(PRE_W);
      end
      limit   = (LIM_W'(1) << div_sat) - LIM_W'(1);
      pre_ext = {1'b0, pre_q};
   end

   assign halted     = halt_q;
   assign pre_active = timer_en & div_en & ~halted;
   assign wr_any     = |counter_write_sel;

   // Prescaler next state and count tick; >= gives an immediate tick
   // when the limit is lowered below the current prescaler value
   always_comb begin
      pre_d = pre_q;
      tick  = 1'b0;
      if (halted) begin
         pre_d = pre_q;
         tick  = 1'b0;
      end else if (pre_active) begin
         if (pre_ext >= limit) begin
            tick  = 1'b1;
            pre_d = '0;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end else begin
         pre_d = '0;
         tick  = timer_en & ~div_en;
      end
      if (counter_clear) begin
         pre_d = '0;
      end
   end

   // Counter next state: clear beats write, write beats tick
   always_comb begin
      cnt_d = cnt_q;
      if (counter_clear) begin
         cnt_d = '0;
      end else if (wr_any) begin
         if (counter_write_sel[0]) begin
            cnt_d[HALF-1:0] = counter_write_data;
         end
         if (counter_write_sel[1]) begin
            cnt_d[CNT_W-1:HALF] = counter_write_data;
         end
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Halt acknowledge follows the qualified request with one cycle delay
   always_comb begin
      halt_d = halt_req & dbg_mode;
   end

   // State registers
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q  <= '0;
         pre_q  <= '0;
         halt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pre_q  <= pre_d;
         halt_q <= halt_d;
      end
   end

   assign cnt_val         = cnt_q;
   assign halt_ack_status = halt_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, counting, prescaler,
// word writes, wrap, halt handshake and clear/write priority.
module tb_timer_counter;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        timer_en;
   logic        div_en;
   logic [3:0]  div_val;
   logic        halt_req;
   logic        dbg_mode;
   logic        counter_clear;
   logic [1:0]  counter_write_sel;
   logic [31:0] counter_write_data;
   logic [63:0] cnt_val;
   logic        halt_ack_status;

   int n_checks = 0;
   int n_fail   = 0;

   timer_counter dut (
      .sys_clk            (sys_clk),
      .sys_rst            (sys_rst),
      .timer_en           (timer_en),
      .div_en             (div_en),
      .div_val            (div_val),
      .halt_req           (halt_req),
      .dbg_mode           (dbg_mode),
      .counter_clear      (counter_clear),
      .counter_write_sel  (counter_write_sel),
      .counter_write_data (counter_write_data),
      .cnt_val            (cnt_val),
      .halt_ack_status    (halt_ack_status)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance n rising edges, land 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic do_clear();
      counter_clear = 1'b1;
      step(1);
      counter_clear = 1'b0;
   endtask

   task automatic do_write(input logic [1:0] sel, input logic [31:0] d);
      counter_write_sel  = sel;
      counter_write_data = d;
      step(1);
      counter_write_sel  = 2'b00;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      timer_en = 0; div_en = 0; div_val = 0;
      halt_req = 0; dbg_mode = 0; counter_clear = 0;
      counter_write_sel = 0; counter_write_data = 0;
      step(2);
      n_checks++;
      if (cnt_val !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %h expected %h", cnt_val, 64'd0);
      end
      n_checks++;
      if (halt_ack_status !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ack: got %b expected 0", halt_ack_status);
      end
      sys_rst = 1'b0;
      step(1);
   endtask

   task automatic test_count_async_reset();
      timer_en = 1; div_en = 0;
      step(10);
      n_checks++;
      if (cnt_val !== 64'd10) begin
         n_fail++;
         $display("FAIL count10: got %h expected %h", cnt_val, 64'd10);
      end
      #3;
      sys_rst = 1'b1;
      #1;
      n_checks++;
      if (cnt_val !== 64'd0) begin
         n_fail++;
         $display("FAIL async_rst_cnt: got %h expected %h", cnt_val, 64'd0);
      end
      n_checks++;
      if (halt_ack_status !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst_ack: got %b expected 0", halt_ack_status);
      end
      step(1);
      sys_rst = 1'b0;
      timer_en = 0;
      step(1);
   endtask

   task automatic test_prescaler();
      div_en = 1; div_val = 4'd3; timer_en = 1;
      step(7);
      n_checks++;
      if (cnt_val !== 64'd0) begin
         n_fail++;
         $display("FAIL div3_edge7: got %h expected %h", cnt_val, 64'd0);
      end
      step(1);
      n_checks++;
      if (cnt_val !== 64'd1) begin
         n_fail++;
         $display("FAIL div3_edge8: got %h expected %h", cnt_val, 64'd1);
      end
      step(32);
      n_checks++;
      if (cnt_val !== 64'd5) begin
         n_fail++;
         $display("FAIL div3_edge40: got %h expected %h", cnt_val, 64'd5);
      end
      // Lower the limit below the prescaler value: tick at the next edge
      step(5);
      div_val = 4'd1;
      step(1);
      n_checks++;
      if (cnt_val !== 64'd6) begin
         n_fail++;
         $display("FAIL limit_drop: got %h expected %h", cnt_val, 64'd6);
      end
      timer_en = 0;
      do_clear();
      div_val = 4'd0; timer_en = 1;
      step(5);
      n_checks++;
      if (cnt_val !== 64'd5) begin
         n_fail++;
         $display("FAIL div0: got %h expected %h", cnt_val, 64'd5);
      end
      // Exponent above 8 saturates to a ratio of 256
      timer_en = 0;
      do_clear();
      div_val = 4'd15; timer_en = 1;
      step(255);
      n_checks++;
      if (cnt_val !== 64'd0) begin
         n_fail++;
         $display("FAIL sat_edge255: got %h expected %h", cnt_val, 64'd0);
      end
      step(1);
      n_checks++;
      if (cnt_val !== 64'd1) begin
         n_fail++;
         $display("FAIL sat_edge256: got %h expected %h", cnt_val, 64'd1);
      end
      timer_en = 0; div_en = 0; div_val = 0;
      do_clear();
   endtask

   task automatic test_wrap();
      do_write(2'b01, 32'hFFFF_FFFF);
      do_write(2'b10, 32'h0000_0001);
      n_checks++;
      if (cnt_val !== 64'h0000_0001_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL write_words: got %h expected %h",
                  cnt_val, 64'h0000_0001_FFFF_FFFF);
      end
      timer_en = 1;
      step(1);
      timer_en = 0;
      n_checks++;
      if (cnt_val !== 64'h0000_0002_0000_0000) begin
         n_fail++;
         $display("FAIL carry: got %h expected %h",
                  cnt_val, 64'h0000_0002_0000_0000);
      end
      do_write(2'b11, 32'hFFFF_FFFF);
      n_checks++;
      if (cnt_val !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL write_both: got %h expected %h",
                  cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      timer_en = 1;
      step(1);
      timer_en = 0;
      n_checks++;
      if (cnt_val !== 64'd0) begin
         n_fail++;
         $display("FAIL wrap: got %h expected %h", cnt_val, 64'd0);
      end
      step(1);
   endtask

   task automatic test_halt();
      do_clear();
      timer_en = 1; div_en = 0;
      step(3);
      halt_req = 1; dbg_mode = 1;
      step(1);
      n_checks++;
      if (halt_ack_status !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_ack_rise: got %b expected 1", halt_ack_status);
      end
      n_checks++;
      if (cnt_val !== 64'd4) begin
         n_fail++;
         $display("FAIL halt_last_inc: got %h expected %h", cnt_val, 64'd4);
      end
      step(5);
      n_checks++;
      if (cnt_val !== 64'd4) begin
         n_fail++;
         $display("FAIL halt_frozen: got %h expected %h", cnt_val, 64'd4);
      end
      dbg_mode = 0;
      step(1);
      n_checks++;
      if (halt_ack_status !== 1'b0 || cnt_val !== 64'd4) begin
         n_fail++;
         $display("FAIL halt_release: got ack=%b cnt=%h expected ack=0 cnt=%h",
                  halt_ack_status, cnt_val, 64'd4);
      end
      step(3);
      n_checks++;
      if (cnt_val !== 64'd7) begin
         n_fail++;
         $display("FAIL halt_resume: got %h expected %h", cnt_val, 64'd7);
      end
      // Request without debug mode is ignored
      halt_req = 1; dbg_mode = 0;
      step(3);
      n_checks++;
      if (halt_ack_status !== 1'b0 || cnt_val !== 64'd10) begin
         n_fail++;
         $display("FAIL halt_nodbg: got ack=%b cnt=%h expected ack=0 cnt=%h",
                  halt_ack_status, cnt_val, 64'd10);
      end
      halt_req = 0;
      timer_en = 0;
      step(1);
   endtask

   task automatic test_clear_write();
      do_clear();
      do_write(2'b01, 32'h0000_0055);
      div_en = 1; div_val = 4'd2; timer_en = 1;
      step(2);
      counter_clear      = 1'b1;
      counter_write_sel  = 2'b01;
      counter_write_data = 32'h0000_00AA;
      step(1);
      counter_clear      = 1'b0;
      counter_write_sel  = 2'b00;
      n_checks++;
      if (cnt_val !== 64'd0) begin
         n_fail++;
         $display("FAIL clear_wins: got %h expected %h", cnt_val, 64'd0);
      end
      // Prescaler restarted from 0: four more edges to the next tick
      step(3);
      n_checks++;
      if (cnt_val !== 64'd0) begin
         n_fail++;
         $display("FAIL clear_pre_hold: got %h expected %h", cnt_val, 64'd0);
      end
      step(1);
      n_checks++;
      if (cnt_val !== 64'd1) begin
         n_fail++;
         $display("FAIL clear_pre_tick: got %h expected %h", cnt_val, 64'd1);
      end
      timer_en = 0; div_en = 0; div_val = 0;
      do_clear();
   endtask

   task automatic test_write_tick();
      do_write(2'b10, 32'h0000_0003);
      do_write(2'b01, 32'h0000_0010);
      timer_en = 1; div_en = 0;
      counter_write_sel  = 2'b01;
      counter_write_data = 32'hABCD_0000;
      step(1);
      counter_write_sel  = 2'b00;
      n_checks++;
      if (cnt_val !== 64'h0000_0003_ABCD_0000) begin
         n_fail++;
         $display("FAIL write_tick: got %h expected %h",
                  cnt_val, 64'h0000_0003_ABCD_0000);
      end
      step(1);
      n_checks++;
      if (cnt_val !== 64'h0000_0003_ABCD_0001) begin
         n_fail++;
         $display("FAIL after_write: got %h expected %h",
                  cnt_val, 64'h0000_0003_ABCD_0001);
      end
      timer_en = 0;
      step(1);
   endtask

   initial begin
      test_reset();
      test_count_async_reset();
      test_prescaler();
      test_wrap();
      test_halt();
      test_clear_write();
      test_write_tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
